bin2thermo_dwa: RTL and testbench
=================================

# bin2thermo_dwa

Binary-to-thermometer encoder with data-weighted-averaging (DWA) element rotation, feeding the 8-element unit DAC array of the oversampled signal path. Each valid 4-bit count (0–8) is expanded into an 8-bit unit-element enable word. The word is rotated by a running pointer so that element mismatch is first-order noise-shaped. The output is registered and one cycle behind the input. The population count of every output word equals the saturated input count.

## Interface
- `N_ELEM`, default 8: number of unit elements and the output width. Only 8 is supported.
- `PTR_W`, default 3: pointer width, equal to log2(`N_ELEM`).
- `CLK`, input, 1: rising-edge clock.
- `RST`, input, 1: asynchronous, active-high reset.
- `Input`, input, 4: binary element count. The legal range is 0–8; values 9–15 saturate to 8.
- `In_valid`, input, 1: qualifies `Input` for one cycle. There is no backpressure.
- `Clear`, input, 1: synchronous pointer clear.
- `Output`, output, 8: registered element-enable word.
- `Out_valid`, output, 1: registered copy of `In_valid`.
- `Pointer`, output, 3: current rotation pointer, the register value.
- `Sat`, output, 1: one-cycle pulse when the accepted `Input` was greater than 8.

## Operation
- Saturated count: `code` = 8 if `Input` > 8, otherwise `code` = `Input`.
- Effective pointer: `p` = 0 if `Clear`=1, otherwise `p` = `Pointer`.
- Output update on a cycle with `In_valid`=1:
  - Bits `p`, `p`+1, …, `p`+`code`−1 (all mod 8) of `Output` are set to 1; all other bits are 0.
  - `code`=0 gives `Output` = 0x00.
  - `code`=8 gives `Output` = 0xFF.
- Pointer update on a cycle with `In_valid`=1: `Pointer` ← (`p` + `code`) mod 8.
  - This is a 4-bit sum truncated to 3 bits.
  - `code`=8 leaves `Pointer` equal to `p`.
- `Clear` and `In_valid` together: the current sample uses pointer 0, and the next pointer is `code` mod 8.
- `Clear` with `In_valid`=0: `Pointer` ← 0 and `Output` holds its value.
- On a cycle with `In_valid`=0:
  - `Output` holds its last value.
  - `Out_valid` ← 0.
  - `Sat` ← 0.
  - `Pointer` holds, unless `Clear` is asserted.
- `Sat` ← (`In_valid` AND `Input` > 8), registered.
- The block has no state machine beyond the pointer register. Each cycle with `In_valid` is an independent transaction.

## Timing
- Latency is exactly 1 cycle: the input sampled at rising edge k appears on `Output`, `Out_valid`, and `Sat` after edge k.
- `Pointer` updates on the same edge as `Output`.
- Throughput is one sample per cycle. Back-to-back `In_valid` is fully supported.
- Reset values: `Output` = 0x00, `Out_valid` = 0, `Pointer` = 0, `Sat` = 0.
- Reset takes effect immediately on assertion, independent of `CLK`.
- Reset mid-stream: any in-flight sample is discarded. The first valid input after reset deassertion uses pointer 0.
- The input is sampled at the first rising edge after `RST` falls.
- There are no combinational paths from inputs to outputs.

## Configuration
- `BIN2THERMO_DWA_EN` defined: rotation is active as described above.
- `BIN2THERMO_DWA_EN` undefined:
  - `p` is always 0, so `Output` is a plain thermometer code with bits 0…`code`−1 set.
  - `Pointer` is constant 0.
  - `Clear` is ignored.
  - Latency, `Out_valid`, `Sat`, and reset behaviour are unchanged.

## Test plan
- **Reset:** assert `RST` mid-stream, asynchronously between edges → `Output` = 0x00, `Out_valid` = 0, `Pointer` = 0, `Sat` = 0 immediately.
- **Rotation (DWA on):** `In_valid` on three consecutive cycles with `Input` = 3, 3, 3 → `Output` = 0x07, 0x38, 0xC1 and `Pointer` = 3, 6, 1, each one cycle later.
- **Extremes and wrap:**
  - From `Pointer` = 5, `Input` = 8 → `Output` = 0xFF, `Pointer` stays 5.
  - Then `Input` = 0 → `Output` = 0x00 with `Out_valid` = 1, `Pointer` stays 5.
  - Then `Input` = 4 → `Output` = 0xE1, `Pointer` = 1.
- **Saturation:** `Input` = 12 at `Pointer` = 2 → `Output` = 0xFF, `Sat` = 1 for one cycle, `Pointer` stays 2. An idle cycle follows → `Sat` = 0, `Output` holds 0xFF.
- **Clear collision:** at `Pointer` = 5, `Clear` = 1 with `In_valid` = 1 and `Input` = 2 → `Output` = 0x03, `Pointer` = 2. `Clear` alone → `Pointer` = 0, `Output` unchanged.
- **DWA off (`BIN2THERMO_DWA_EN` undefined):** `Input` = 3, 3, 5 → `Output` = 0x07, 0x07, 0x1F, `Pointer` = 0 throughout. For random streams, the popcount of `Output` always equals the saturated `Input`.

Source files
------------

// File: rtl/bin2thermo_dwa.sv
// rtl/bin2thermo_dwa.sv - binary-to-thermometer encoder with DWA rotation (BIN2THERMO_DWA_EN enables rotation)
module bin2thermo_dwa #(
    parameter int N_ELEM = 8,
    parameter int PTR_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        Input,
    input  logic              In_valid,
    input  logic              Clear,
    output logic [N_ELEM-1:0] Output,
    output logic              Out_valid,
    output logic [PTR_W-1:0]  Pointer,
    output logic              Sat
);

    logic [3:0]          code;
    logic                over;
    logic [N_ELEM-1:0]   thermo;
    logic [2*N_ELEM-1:0] dbl;
    logic [N_ELEM-1:0]   rot;
    logic [PTR_W-1:0]    p;
    logic [3:0]          ptr_sum;
    logic [PTR_W-1:0]    ptr_q;

    assign over = (Input > 4'd8);
    assign code = over ? 4'd8 : Input;

    always_comb begin
        thermo = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            thermo[i] = (4'(i) < code);
        end
    end

`ifdef BIN2THERMO_DWA_EN
    assign p = Clear ? '0 : ptr_q;
`else
    logic unused_clear;
    assign unused_clear = Clear;
    assign p = '0;
`endif

    // Rotate left by p: shift a doubled copy and keep the upper half so wrapped bits land at the bottom.
    assign dbl     = {thermo, thermo} << p;
    assign rot     = dbl[2*N_ELEM-1:N_ELEM];
    assign ptr_sum = {1'b0, p} + code;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Output    <= '0;
            Out_valid <= 1'b0;
            Sat       <= 1'b0;
            ptr_q     <= '0;
        end else begin
            Out_valid <= In_valid;
            Sat       <= In_valid & over;
            if (In_valid) begin
                Output <= rot;
            end
`ifdef BIN2THERMO_DWA_EN
            if (In_valid) begin
                ptr_q <= ptr_sum[PTR_W-1:0];
            end else if (Clear) begin
                ptr_q <= '0;
            end
`else
            ptr_q <= '0;
`endif
        end
    end

    assign Pointer = ptr_q;

endmodule

// File: tb/tb_bin2thermo_dwa.sv
// tb/tb_bin2thermo_dwa.sv - directed and random self-checking bench for bin2thermo_dwa
module tb_bin2thermo_dwa;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] Input;
    logic       In_valid;
    logic       Clear;
    logic [7:0] Output;
    logic       Out_valid;
    logic [2:0] Pointer;
    logic       Sat;

    int checks = 0;
    int errors = 0;

`ifdef BIN2THERMO_DWA_EN
    localparam bit DWA = 1'b1;
`else
    localparam bit DWA = 1'b0;
`endif

    typedef struct {
        logic [3:0] in;
        logic       v;
        logic       c;
        logic [7:0] o;
        logic       ov;
        logic [2:0] p;
        logic       s;
    } vec_t;

    always #5 CLK = ~CLK;

    bin2thermo_dwa #(.N_ELEM(8), .PTR_W(3)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Input    (Input),
        .In_valid (In_valid),
        .Clear    (Clear),
        .Output   (Output),
        .Out_valid(Out_valid),
        .Pointer  (Pointer),
        .Sat      (Sat)
    );

    task automatic drive(input logic [3:0] in, input logic v, input logic c);
        @(negedge CLK);
        Input    = in;
        In_valid = v;
        Clear    = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; Input = 4'd0; In_valid = 1'b0; Clear = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        RST = 1'b1; Input = 4'd0; In_valid = 1'b0; Clear = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        obs = {Output, Out_valid, Pointer, Sat};
        checks++;
        if (obs !== 13'h0) begin
            errors++; $display("FAIL reset_state got %h exp %h", obs, 13'h0);
        end
        @(negedge CLK);
        RST = 1'b0;
        drive(4'd12, 1'b1, 1'b0);
        obs = {Output, Out_valid, Pointer, Sat};
        checks++;
        if (obs !== {8'hFF, 1'b1, 3'd0, 1'b1}) begin
            errors++; $display("FAIL reset_prefill got %h exp %h", obs, {8'hFF, 1'b1, 3'd0, 1'b1});
        end
        #2 RST = 1'b1;
        #1;
        obs = {Output, Out_valid, Pointer, Sat};
        checks++;
        if (obs !== 13'h0) begin
            errors++; $display("FAIL reset_async got %h exp %h", obs, 13'h0);
        end
        @(posedge CLK);
        #1;
        obs = {Output, Out_valid, Pointer, Sat};
        checks++;
        if (obs !== 13'h0) begin
            errors++; $display("FAIL reset_held got %h exp %h", obs, 13'h0);
        end
        @(negedge CLK);
        RST = 1'b0; In_valid = 1'b0;
        drive(4'd3, 1'b1, 1'b0);
        obs = {Output, Out_valid, Pointer, Sat};
        checks++;
        if (obs !== {8'h07, 1'b1, (DWA ? 3'd3 : 3'd0), 1'b0}) begin
            errors++; $display("FAIL reset_first got %h exp %h", obs, {8'h07, 1'b1, (DWA ? 3'd3 : 3'd0), 1'b0});
        end
    endtask

    task automatic test_saturation();
        vec_t vs[6];
        logic [12:0] obs, expv;
        do_reset();
        vs[0] = '{4'd12, 1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1};
        vs[1] = '{4'd0,  1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0};
        vs[2] = '{4'd9,  1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1};
        vs[3] = '{4'd8,  1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b0};
        vs[4] = '{4'd15, 1'b1, 1'b0, 8'hFF, 1'b1, 3'd0, 1'b1};
        vs[5] = '{4'd0,  1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(vs[i].in, vs[i].v, vs[i].c);
            obs  = {Output, Out_valid, Pointer, Sat};
            expv = {vs[i].o, vs[i].ov, vs[i].p, vs[i].s};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL sat_step%0d got %h exp %h", i, obs, expv);
            end
        end
    endtask

`ifdef BIN2THERMO_DWA_EN
    task automatic test_rotation();
        vec_t vs[14];
        logic [12:0] obs, expv;
        do_reset();
        vs[0]  = '{4'd3,  1'b1, 1'b0, 8'h07, 1'b1, 3'd3, 1'b0};
        vs[1]  = '{4'd3,  1'b1, 1'b0, 8'h38, 1'b1, 3'd6, 1'b0};
        vs[2]  = '{4'd3,  1'b1, 1'b0, 8'hC1, 1'b1, 3'd1, 1'b0};
        vs[3]  = '{4'd4,  1'b1, 1'b0, 8'h1E, 1'b1, 3'd5, 1'b0};
        vs[4]  = '{4'd8,  1'b1, 1'b0, 8'hFF, 1'b1, 3'd5, 1'b0};
        vs[5]  = '{4'd0,  1'b1, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0};
        vs[6]  = '{4'd4,  1'b1, 1'b0, 8'hE1, 1'b1, 3'd1, 1'b0};
        vs[7]  = '{4'd1,  1'b1, 1'b0, 8'h02, 1'b1, 3'd2, 1'b0};
        vs[8]  = '{4'd12, 1'b1, 1'b0, 8'hFF, 1'b1, 3'd2, 1'b1};
        vs[9]  = '{4'd0,  1'b0, 1'b0, 8'hFF, 1'b0, 3'd2, 1'b0};
        vs[10] = '{4'd3,  1'b1, 1'b0, 8'h1C, 1'b1, 3'd5, 1'b0};
        vs[11] = '{4'd2,  1'b1, 1'b1, 8'h03, 1'b1, 3'd2, 1'b0};
        vs[12] = '{4'd0,  1'b0, 1'b1, 8'h03, 1'b0, 3'd0, 1'b0};
        vs[13] = '{4'd3,  1'b1, 1'b0, 8'h07, 1'b1, 3'd3, 1'b0};
        for (int i = 0; i < 14; i++) begin
            drive(vs[i].in, vs[i].v, vs[i].c);
            obs  = {Output, Out_valid, Pointer, Sat};
            expv = {vs[i].o, vs[i].ov, vs[i].p, vs[i].s};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL rot_step%0d got %h exp %h", i, obs, expv);
            end
        end
    endtask
`else
    task automatic test_thermo();
        vec_t vs[7];
        logic [12:0] obs, expv;
        do_reset();
        vs[0] = '{4'd3, 1'b1, 1'b0, 8'h07, 1'b1, 3'd0, 1'b0};
        vs[1] = '{4'd3, 1'b1, 1'b0, 8'h07, 1'b1, 3'd0, 1'b0};
        vs[2] = '{4'd5, 1'b1, 1'b0, 8'h1F, 1'b1, 3'd0, 1'b0};
        vs[3] = '{4'd2, 1'b1, 1'b1, 8'h03, 1'b1, 3'd0, 1'b0};
        vs[4] = '{4'd0, 1'b0, 1'b1, 8'h03, 1'b0, 3'd0, 1'b0};
        vs[5] = '{4'd7, 1'b1, 1'b0, 8'h7F, 1'b1, 3'd0, 1'b0};
        vs[6] = '{4'd1, 1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(vs[i].in, vs[i].v, vs[i].c);
            obs  = {Output, Out_valid, Pointer, Sat};
            expv = {vs[i].o, vs[i].ov, vs[i].p, vs[i].s};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL thermo_step%0d got %h exp %h", i, obs, expv);
            end
        end
    endtask
`endif

    task automatic test_back_to_back_random();
        logic [2:0]  m_ptr, p;
        logic [7:0]  m_out;
        logic [3:0]  in, code;
        logic        v, c;
        logic [12:0] obs, expv;
        do_reset();
        m_ptr = 3'd0;
        m_out = 8'h00;
        for (int i = 0; i < 60; i++) begin
            in   = 4'($urandom_range(0, 15));
            v    = ($urandom_range(0, 3) != 0);
            c    = ($urandom_range(0, 4) == 0);
            code = (in > 4'd8) ? 4'd8 : in;
            p    = (DWA && !c) ? m_ptr : 3'd0;
            if (v) begin
                m_out = 8'h00;
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(code)) m_out[(int'(p) + j) % 8] = 1'b1;
                end
                m_ptr = DWA ? 3'((int'(p) + int'(code)) % 8) : 3'd0;
            end else if (DWA && c) begin
                m_ptr = 3'd0;
            end
            drive(in, v, c);
            obs  = {Output, Out_valid, Pointer, Sat};
            expv = {m_out, v, m_ptr, (v && in > 4'd8)};
            checks++;
            if (obs !== expv) begin
                errors++; $display("FAIL rand_step%0d in=%0d v=%b c=%b got %h exp %h", i, in, v, c, obs, expv);
            end
            if (v) begin
                checks++;
                if ($countones(Output) !== int'(code)) begin
                    errors++; $display("FAIL rand_popcount%0d got %0d exp %0d", i, $countones(Output), code);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_saturation();
`ifdef BIN2THERMO_DWA_EN
        test_rotation();
`else
        test_thermo();
`endif
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
